// File: rtl/rvx_dma_copy.sv
// rtl/rvx_dma_copy.sv - word-by-word DMA copy initiator on the RVX memory interface
module rvx_dma_copy #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            src_address,
  input  logic [31:0]            dst_address,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] words_done,
  output logic [31:0]            rw_address,
  input  logic [31:0]            read_data,
  output logic                   read_request,
  input  logic                   read_response,
  output logic [31:0]            write_data,
  output logic [3:0]             write_strobe,
  output logic                   write_request,
  input  logic                   write_response
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERROR} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d, words_q, words_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   error_q, error_d;
  logic                   tmo_hit;

  assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign error      = error_q;
  assign words_done = words_q;

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    data_d        = data_q;
    count_d       = count_q;
    words_d       = words_q;
    tmo_d         = tmo_q;
    error_d       = error_q;
    busy          = 1'b0;
    done          = 1'b0;
    rw_address    = 32'h0;
    read_request  = 1'b0;
    write_request = 1'b0;
    write_data    = 32'h0;
    write_strobe  = 4'h0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (word_count == '0) begin
            state_d = S_DONE;
          end else if ((src_address[1:0] | dst_address[1:0]) != 2'b00) begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end else begin
            src_d   = src_address;
            dst_d   = dst_address;
            count_d = word_count;
            words_d = '0;
            tmo_d   = '0;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        busy         = 1'b1;
        read_request = 1'b1;
        rw_address   = src_q;
        if (read_response) begin
          data_d  = read_data;
          src_d   = src_q + 32'd4;
          tmo_d   = '0;
          state_d = S_WRITE;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WRITE: begin
        busy          = 1'b1;
        write_request = 1'b1;
        rw_address    = dst_q;
        write_data    = data_q;
        write_strobe  = 4'hF;
        if (write_response) begin
          dst_d   = dst_q + 32'd4;
          words_d = words_q + COUNT_WIDTH'(1);
          tmo_d   = '0;
          state_d = ((words_q + COUNT_WIDTH'(1)) == count_q) ? S_DONE : S_READ;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      words_q <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      count_q <= count_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_rvx_dma_copy.sv
// tb/tb_rvx_dma_copy.sv - self-checking bench for rvx_dma_copy with a RAM responder model
module tb_rvx_dma_copy;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [31:0] src_address, dst_address;
  logic [15:0] word_count;
  logic        busy, done, error;
  logic [15:0] words_done;
  logic [31:0] rw_address, read_data, write_data;
  logic        read_request, read_response, write_request, write_response;
  logic [3:0]  write_strobe;

  rvx_dma_copy #(.TIMEOUT_CYCLES(8), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_address(src_address), .dst_address(dst_address), .word_count(word_count),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .rw_address(rw_address), .read_data(read_data), .read_request(read_request),
    .read_response(read_response), .write_data(write_data), .write_strobe(write_strobe),
    .write_request(write_request), .write_response(write_response)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pat(input int i);
    logic [15:0] w;
    w = 16'(i);
    return {w ^ 16'hC0DE, w};
  endfunction

  // Responder: one-cycle registered RAM, optional response throttling, 4 KB address window
  logic [31:0] mem [0:1023];
  logic        resp_en, mask_en, init_mem;
  int          cyc = 0, rd_x = 0, wr_x = 0;
  wire         allow = !mask_en || (cyc % 3 == 0);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (write_request && write_response) begin
      mem[rw_address[11:2]] <= write_data;
    end
    if (read_request && read_response) rd_x <= rd_x + 1;
    if (write_request && write_response) wr_x <= wr_x + 1;
    read_data <= mem[rw_address[11:2]];
    if (reset) begin
      read_response  <= 1'b0;
      write_response <= 1'b0;
    end else begin
      read_response  <= resp_en && read_request && !read_response && allow;
      write_response <= resp_en && write_request && !write_response && allow;
    end
  end

  // Bus monitor: request cycles, done pulses, stability of address/data/strobe
  int          rd_cyc = 0, wr_cyc = 0, done_cnt = 0, stab_err = 0;
  logic        rq_p = 1'b0, wq_p = 1'b0;
  logic [31:0] a_p = '0, d_p = '0;

  always @(negedge clock) begin
    if (read_request) rd_cyc <= rd_cyc + 1;
    if (write_request) wr_cyc <= wr_cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if ((read_request && rq_p && rw_address != a_p) ||
        (write_request && wq_p && (rw_address != a_p || write_data != d_p)) ||
        (write_request && write_strobe != 4'hF) || (!write_request && write_strobe != 4'h0))
      stab_err <= stab_err + 1;
    rq_p <= read_request;
    wq_p <= write_request;
    a_p  <= rw_address;
    d_p  <= write_data;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] n;
    bit          masked;
    bit          exp_err;
    logic [15:0] exp_wd;
    int          exp_lat;
    int          exp_xfers;
  } vec_t;

  vec_t vecs[7];
  int   b_rd, b_wr, b_rx, b_wx, b_done, lat;

  task automatic fill_mem();
    @(negedge clock); init_mem = 1'b1;
    @(negedge clock); init_mem = 1'b0;
  endtask

  // Issues a start and waits for done; leaves the bench one cycle past the done pulse
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clock);
    b_rd = rd_cyc; b_wr = wr_cyc; b_rx = rd_x; b_wx = wr_x; b_done = done_cnt;
    start = 1'b1; src_address = s; dst_address = d; word_count = n;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 2000) chk("done_timeout", 32'(lat), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    vecs[0] = '{32'h100,      32'h200, 16'd4, 1'b0, 1'b0, 16'd4, 17, 4};
    vecs[1] = '{32'h100,      32'h200, 16'd4, 1'b1, 1'b0, 16'd4, -1, 4};
    vecs[2] = '{32'hFFFFFFFC, 32'h400, 16'd2, 1'b0, 1'b0, 16'd2,  9, 2};
    vecs[3] = '{32'h102,      32'h200, 16'd4, 1'b0, 1'b1, 16'd2,  1, 0};
    vecs[4] = '{32'h100,      32'h201, 16'd1, 1'b0, 1'b1, 16'd2,  1, 0};
    vecs[5] = '{32'h300,      32'h500, 16'd3, 1'b0, 1'b0, 16'd3, 13, 3};
    vecs[6] = '{32'h300,      32'h500, 16'd0, 1'b0, 1'b0, 16'd3,  1, 0};

    reset = 1'b1; start = 1'b0; src_address = '0; dst_address = '0; word_count = '0;
    resp_en = 1'b1; mask_en = 1'b0; init_mem = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    chk("rst_requests", {30'd0, read_request, write_request}, 32'd0);
    chk("rst_bus", rw_address | write_data | 32'(write_strobe), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      mask_en = vecs[v].masked;
      fill_mem();
      do_start(vecs[v].src, vecs[v].dst, vecs[v].n);
      if (vecs[v].exp_lat >= 0) chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("v%0d_done_pulses", v), 32'(done_cnt - b_done), 32'd1);
      chk($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_words_done", v), 32'(words_done), 32'(vecs[v].exp_wd));
      chk($sformatf("v%0d_busy_after", v), 32'(busy), 32'd0);
      if (vecs[v].exp_xfers == 0) begin
        chk($sformatf("v%0d_no_requests", v), 32'((rd_cyc - b_rd) + (wr_cyc - b_wr)), 32'd0);
      end else begin
        chk($sformatf("v%0d_reads", v), 32'(rd_x - b_rx), 32'(vecs[v].exp_xfers));
        chk($sformatf("v%0d_writes", v), 32'(wr_x - b_wx), 32'(vecs[v].exp_xfers));
        for (int k = 0; k < vecs[v].exp_xfers; k++) begin
          logic [31:0] sa, da;
          sa = vecs[v].src + 32'(4 * k);
          da = vecs[v].dst + 32'(4 * k);
          chk($sformatf("v%0d_mem%0d", v, k), mem[da[11:2]], pat(int'(sa[11:2])));
        end
      end
    end

    // Responses withheld: read_request held exactly TIMEOUT_CYCLES, then error
    resp_en = 1'b0; mask_en = 1'b0;
    do_start(32'h100, 32'h200, 16'd2);
    chk("tmo_read_cycles", 32'(rd_cyc - b_rd), 32'd8);
    chk("tmo_write_cycles", 32'(wr_cyc - b_wr), 32'd0);
    chk("tmo_latency", 32'(lat), 32'd9);
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_words_done", 32'(words_done), 32'd0);
    resp_en = 1'b1;

    // Reset during the write of word 2, then a full copy from scratch
    fill_mem();
    @(negedge clock);
    start = 1'b1; src_address = 32'h100; dst_address = 32'h200; word_count = 16'd4;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (!(write_request && words_done == 16'd1) && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    chk("mid_reached_word2_write", 32'(lat < 200), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_requests", {30'd0, read_request, write_request}, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_words_done", 32'(words_done), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    fill_mem();
    do_start(32'h100, 32'h200, 16'd4);
    chk("rerun_words_done", 32'(words_done), 32'd4);
    chk("rerun_error", 32'(error), 32'd0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rerun_mem%0d", k), mem[128 + k], pat(64 + k));

    chk("bus_stability", 32'(stab_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
